dispatch_queue: RTL and testbench

Parametrised dual-lane dispatch buffer between decode and the execution issue ports. Up to two decoded instructions per cycle go into a circular queue of DEPTH entries. NOP slots are dropped on entry. Up to two instructions per cycle leave in program order, and a pair is split when the older instruction's destination feeds or collides with the younger one. Unlike the earlier combinational dispatch stage, this block buffers, applies back-pressure, flushes, and has a single-issue mode.

---
 rtl/dispatch_queue.sv | 152 +++++++++++++++
 tb/tb_dispatch_queue.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// Dual-lane dispatch buffer: a circular queue that takes up to two decoded
// instructions per cycle and issues up to two in program order, splitting hazardous pairs.
module dispatch_queue #(
  parameter int DEPTH   = 8,
  parameter bit PAIR_EN = 1'b1,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_dspch,
  input  logic             in_valid1_dspch,
  input  logic             in_valid2_dspch,
  input  logic [63:0]      inst1_dspch,
  input  logic [63:0]      inst2_dspch,
  output logic             in_ready_dspch,
  output logic             out_valid1_dspch,
  output logic             out_valid2_dspch,
  output logic [63:0]      out_inst1_dspch,
  output logic [63:0]      out_inst2_dspch,
  input  logic             out_ready1_dspch,
  input  logic             out_ready2_dspch,
  output logic [CNT_W-1:0] count_dspch
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam int B_NOP  = 63;
  localparam int B_MEM  = 62;
  localparam int B_FLT  = 61;
  localparam int B_INT  = 60;
  localparam int RR_LO  = 47;
  localparam int OPA_LO = 42;
  localparam int OPB_LO = 37;
  localparam int DST_LO = 32;

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nx1;
  logic [PTR_W-1:0] wr_addr2;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_slots;

  logic             wr1;
  logic             wr2;
  logic             rd1;
  logic             rd2;
  logic [1:0]       n_wr;
  logic [1:0]       n_rd;

  // ---------------- enqueue side ----------------
  assign free_slots     = DEPTH_C - count;
  assign in_ready_dspch = (free_slots >= CNT_W'(2)) && !flush_dspch;

  assign wr1 = in_ready_dspch && in_valid1_dspch && !inst1_dspch[B_NOP];
  assign wr2 = in_ready_dspch && in_valid2_dspch && !inst2_dspch[B_NOP];

  // slot 2 compacts into tail when slot 1 is not written
  assign wr_addr2 = wr1 ? tail + PTR_W'(1) : tail;
  assign n_wr     = {1'b0, wr1} + {1'b0, wr2};

  // ---------------- head pair decode ----------------
  assign head_nx1        = head + PTR_W'(1);
  assign out_inst1_dspch = mem[head];
  assign out_inst2_dspch = mem[head_nx1];

  logic       h_mem;
  logic       h_flt;
  logic       h_int;
  logic [4:0] h_dst;
  logic       y_mem;
  logic       y_flt;
  logic       y_int;
  logic       y_rd_a;
  logic       y_rd_b;
  logic       y_fcls;
  logic [4:0] y_opa;
  logic [4:0] y_opb;
  logic [4:0] y_dst;

  assign h_mem  = out_inst1_dspch[B_MEM];
  assign h_flt  = out_inst1_dspch[B_FLT];
  assign h_int  = out_inst1_dspch[B_INT];
  assign h_dst  = out_inst1_dspch[DST_LO +: 5];
  assign y_mem  = out_inst2_dspch[B_MEM];
  assign y_flt  = out_inst2_dspch[B_FLT];
  assign y_int  = out_inst2_dspch[B_INT];
  assign y_rd_a = out_inst2_dspch[RR_LO];
  assign y_rd_b = out_inst2_dspch[RR_LO + 1];
  assign y_fcls = out_inst2_dspch[RR_LO + 2];
  assign y_opa  = out_inst2_dspch[OPA_LO +: 5];
  assign y_opb  = out_inst2_dspch[OPB_LO +: 5];
  assign y_dst  = out_inst2_dspch[DST_LO +: 5];

  logic h_int_w;
  logic h_flt_w;
  logic h_cls_w;
  logic raw_haz;
  logic waw_haz;
  logic mem_haz;
  logic hazard;

  // int r0 is hard-wired zero, so writes to it never create a dependency
  assign h_int_w = h_int && (h_dst != 5'd0);
  assign h_flt_w = h_flt;
  assign h_cls_w = y_fcls ? h_flt_w : h_int_w;

  assign raw_haz = h_cls_w && ((y_rd_a && (y_opa == h_dst)) ||
                               (y_rd_b && (y_opb == h_dst)));
  assign waw_haz = (h_int_w && y_int && (y_dst == h_dst)) ||
                   (h_flt_w && y_flt && (y_dst == h_dst));
  assign mem_haz = h_mem && y_mem;
  assign hazard  = raw_haz || waw_haz || mem_haz;

  // ---------------- dequeue side ----------------
  assign out_valid1_dspch = (count >= CNT_W'(1)) && !flush_dspch;
  assign out_valid2_dspch = PAIR_EN && (count >= CNT_W'(2)) && !hazard && !flush_dspch;

  assign rd1  = out_valid1_dspch && out_ready1_dspch;
  assign rd2  = out_valid2_dspch && out_ready2_dspch && rd1;
  assign n_rd = {1'b0, rd1} + {1'b0, rd2};

  assign count_dspch = count;

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_dspch) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr1) begin
        mem[tail] <= inst1_dspch;
      end
      if (wr2) begin
        mem[wr_addr2] <= inst2_dspch;
      end
      head  <= head + PTR_W'(n_rd);
      tail  <= tail + PTR_W'(n_wr);
      count <= count + CNT_W'(n_wr) - CNT_W'(n_rd);
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: dual-issue and single-issue instances, scoreboard
// of expected dispatched words checked whenever a lane is consumed.
module tb_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             v1, v2, r1, r2;
  logic [63:0]      i1, i2;
  logic             in_ready, ov1, ov2;
  logic [63:0]      oi1, oi2;
  logic [CNT_W-1:0] cnt;

  logic             s_v1, s_v2, s_r1, s_r2;
  logic [63:0]      s_i1, s_i2;
  logic             s_in_ready, s_ov1, s_ov2;
  logic [63:0]      s_oi1, s_oi2;
  logic [CNT_W-1:0] s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] sb[$];
  logic [63:0] sb_s[$];
  logic [63:0] mon_e;
  logic [63:0] mon_s_e;

  always #5 clk = ~clk;

  dispatch_queue #(.DEPTH(DEPTH), .PAIR_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_dspch(flush),
    .in_valid1_dspch(v1), .in_valid2_dspch(v2),
    .inst1_dspch(i1), .inst2_dspch(i2),
    .in_ready_dspch(in_ready),
    .out_valid1_dspch(ov1), .out_valid2_dspch(ov2),
    .out_inst1_dspch(oi1), .out_inst2_dspch(oi2),
    .out_ready1_dspch(r1), .out_ready2_dspch(r2),
    .count_dspch(cnt)
  );

  dispatch_queue #(.DEPTH(DEPTH), .PAIR_EN(1'b0), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rst(rst), .flush_dspch(flush),
    .in_valid1_dspch(s_v1), .in_valid2_dspch(s_v2),
    .inst1_dspch(s_i1), .inst2_dspch(s_i2),
    .in_ready_dspch(s_in_ready),
    .out_valid1_dspch(s_ov1), .out_valid2_dspch(s_ov2),
    .out_inst1_dspch(s_oi1), .out_inst2_dspch(s_oi2),
    .out_ready1_dspch(s_r1), .out_ready2_dspch(s_r2),
    .count_dspch(s_cnt)
  );

  function automatic logic [63:0] mk(input logic [31:0] pc, input logic nop, input logic memw,
                                     input logic fltw, input logic intw, input logic [3:0] rr,
                                     input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    return {nop, memw, fltw, intw, 6'h11, 3'h2, rr, a, b, d, pc};
  endfunction

  function automatic logic [63:0] ind(input logic [31:0] pc);
    return mk(pc, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0);
  endfunction

  // Scoreboard monitors: compare what each lane hands over against program order.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (ov1 && r1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL lane1_unexpected: got %h required none", oi1);
        end else begin
          mon_e = sb.pop_front();
          if (oi1 !== mon_e) begin n_err++; $display("FAIL lane1_order: got %h required %h", oi1, mon_e); end
        end
        if (ov2 && r2) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++; $display("FAIL lane2_unexpected: got %h required none", oi2);
          end else begin
            mon_e = sb.pop_front();
            if (oi2 !== mon_e) begin n_err++; $display("FAIL lane2_order: got %h required %h", oi2, mon_e); end
          end
        end
      end
      if (s_ov1 && s_r1) begin
        n_cmp++;
        if (sb_s.size() == 0) begin
          n_err++; $display("FAIL s_lane1_unexpected: got %h required none", s_oi1);
        end else begin
          mon_s_e = sb_s.pop_front();
          if (s_oi1 !== mon_s_e) begin n_err++; $display("FAIL s_lane1_order: got %h required %h", s_oi1, mon_s_e); end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; v1 = 0; v2 = 0; r1 = 0; r2 = 0; i1 = '0; i2 = '0;
    s_v1 = 0; s_v2 = 0; s_r1 = 0; s_r2 = 0; s_i1 = '0; s_i2 = '0;
  endtask

  task automatic push_pair(input logic [63:0] a, input logic [63:0] b);
    v1 = 1; v2 = 1; i1 = a; i2 = b;
    sb.push_back(a); sb.push_back(b);
    tick();
    v1 = 0; v2 = 0;
  endtask

  task automatic push_one(input logic [63:0] a);
    v1 = 1; v2 = 0; i1 = a;
    sb.push_back(a);
    tick();
    v1 = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d required 0", cnt); end
    n_cmp++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b%b required 00", ov1, ov2); end
    n_cmp++; if (oi1 !== 64'd0 || oi2 !== 64'd0) begin n_err++; $display("FAIL reset_inst: got %h %h required 0 0", oi1, oi2); end
    n_cmp++; if (s_cnt !== 4'd0) begin n_err++; $display("FAIL reset_s_count: got %0d required 0", s_cnt); end
    rst = 0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_empty_valid: got %b required 0", ov1); end
  endtask

  task automatic test_single_push();
    push_one(mk(32'h100, 0, 0, 0, 1, 4'h0, 5'd0, 5'd0, 5'd3));
    n_cmp++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL single_valid1: got %b required 1", ov1); end
    n_cmp++; if (oi1[31:0] !== 32'h100) begin n_err++; $display("FAIL single_pc: got %h required 100", oi1[31:0]); end
    n_cmp++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL single_valid2: got %b required 0", ov2); end
    n_cmp++; if (cnt !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d required 1", cnt); end
    r1 = 1; tick(); r1 = 0;
    n_cmp++; if (cnt !== 4'd0 || ov1 !== 1'b0) begin n_err++; $display("FAIL single_drain: got cnt %0d v %b required 0 0", cnt, ov1); end
  endtask

  task automatic test_raw_split();
    push_pair(mk(32'h200, 0, 0, 0, 1, 4'h0, 5'd0, 5'd0, 5'd5),
              mk(32'h204, 0, 0, 0, 0, 4'h1, 5'd5, 5'd0, 5'd0));
    n_cmp++; if (cnt !== 4'd2) begin n_err++; $display("FAIL raw_count: got %0d required 2", cnt); end
    n_cmp++; if (ov1 !== 1'b1 || ov2 !== 1'b0) begin n_err++; $display("FAIL raw_split: got %b%b required 10", ov1, ov2); end
    r1 = 1; r2 = 1; tick();
    n_cmp++; if (cnt !== 4'd1 || oi1[31:0] !== 32'h204) begin n_err++; $display("FAIL raw_second: got cnt %0d pc %h required 1 204", cnt, oi1[31:0]); end
    tick(); r1 = 0; r2 = 0;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL raw_drain: got %0d required 0", cnt); end
    push_pair(mk(32'h210, 0, 0, 0, 1, 4'h0, 5'd0, 5'd0, 5'd0),
              mk(32'h214, 0, 0, 0, 0, 4'h1, 5'd0, 5'd0, 5'd0));
    n_cmp++; if (ov2 !== 1'b1 || oi2[31:0] !== 32'h214) begin n_err++; $display("FAIL raw_dest0: got v2 %b pc %h required 1 214", ov2, oi2[31:0]); end
    r1 = 1; r2 = 1; tick(); r1 = 0; r2 = 0;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL raw_dest0_drain: got %0d required 0", cnt); end
  endtask

  task automatic test_hazards();
    logic [63:0] th[9];
    logic [63:0] ty[9];
    logic        ex[9];
    th[0] = mk(32'h400, 0, 0, 0, 1, 4'h0, 0, 0, 7);  ty[0] = mk(32'h404, 0, 0, 0, 1, 4'h0, 0, 0, 7);  ex[0] = 1;
    th[1] = mk(32'h410, 0, 0, 1, 0, 4'h0, 0, 0, 0);  ty[1] = mk(32'h414, 0, 0, 1, 0, 4'h0, 0, 0, 0);  ex[1] = 1;
    th[2] = mk(32'h420, 0, 0, 0, 1, 4'h0, 0, 0, 0);  ty[2] = mk(32'h424, 0, 0, 0, 1, 4'h0, 0, 0, 0);  ex[2] = 0;
    th[3] = mk(32'h430, 0, 1, 0, 0, 4'h0, 0, 0, 0);  ty[3] = mk(32'h434, 0, 1, 0, 0, 4'h0, 0, 0, 0);  ex[3] = 1;
    th[4] = mk(32'h440, 0, 0, 1, 0, 4'h0, 0, 0, 4);  ty[4] = mk(32'h444, 0, 0, 0, 0, 4'h5, 4, 0, 0);  ex[4] = 1;
    th[5] = mk(32'h450, 0, 0, 0, 1, 4'h0, 0, 0, 4);  ty[5] = mk(32'h454, 0, 0, 0, 0, 4'h5, 4, 0, 0);  ex[5] = 0;
    th[6] = mk(32'h460, 0, 0, 0, 1, 4'h0, 0, 0, 9);  ty[6] = mk(32'h464, 0, 0, 0, 0, 4'h2, 0, 9, 0);  ex[6] = 1;
    th[7] = mk(32'h470, 0, 0, 0, 1, 4'h0, 0, 0, 9);  ty[7] = mk(32'h474, 0, 0, 0, 0, 4'h8, 9, 9, 0);  ex[7] = 0;
    th[8] = mk(32'h480, 0, 0, 1, 0, 4'h0, 0, 0, 4);  ty[8] = mk(32'h484, 0, 0, 0, 0, 4'h1, 4, 0, 0);  ex[8] = 0;
    for (int k = 0; k < 9; k++) begin
      push_pair(th[k], ty[k]);
      n_cmp++; if (ov2 !== !ex[k]) begin n_err++; $display("FAIL hazard_%0d: got v2 %b required %b", k, ov2, !ex[k]); end
      r1 = 1; r2 = 1; tick();
      if (ex[k]) tick();
      r1 = 0; r2 = 0;
      n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL hazard_drain_%0d: got %0d required 0", k, cnt); end
    end
  endtask

  task automatic test_nop_compaction();
    v1 = 1; v2 = 1;
    i1 = mk(32'h200, 1, 0, 0, 1, 4'h0, 0, 0, 3);
    i2 = ind(32'h204); sb.push_back(i2);
    tick(); v1 = 0; v2 = 0;
    n_cmp++; if (cnt !== 4'd1 || oi1[31:0] !== 32'h204) begin n_err++; $display("FAIL nop_slot1: got cnt %0d pc %h required 1 204", cnt, oi1[31:0]); end
    v2 = 1; i2 = ind(32'h208); sb.push_back(i2);
    tick(); v2 = 0;
    n_cmp++; if (cnt !== 4'd2 || ov2 !== 1'b1 || oi2[31:0] !== 32'h208) begin n_err++; $display("FAIL lone_slot2: got cnt %0d v2 %b pc %h required 2 1 208", cnt, ov2, oi2[31:0]); end
    v1 = 1; v2 = 1; i1 = mk(32'h2f0, 1, 0, 0, 0, 4'h0, 0, 0, 0); i2 = mk(32'h2f4, 1, 1, 0, 0, 4'h0, 0, 0, 0);
    tick();
    n_cmp++; if (cnt !== 4'd2) begin n_err++; $display("FAIL nop_both: got %0d required 2", cnt); end
    i1 = ind(32'h20c); sb.push_back(i1);
    tick(); v1 = 0; v2 = 0;
    n_cmp++; if (cnt !== 4'd3) begin n_err++; $display("FAIL nop_slot2: got %0d required 3", cnt); end
    r1 = 1; r2 = 1; tick(); tick(); r1 = 0; r2 = 0;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL nop_drain: got %0d required 0", cnt); end
  endtask

  task automatic test_fill_full();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d: got %b required 1", k, in_ready); end
      push_pair(ind(32'h300 + 8 * k), ind(32'h304 + 8 * k));
    end
    n_cmp++; if (cnt !== 4'd8 || in_ready !== 1'b0) begin n_err++; $display("FAIL full: got cnt %0d rdy %b required 8 0", cnt, in_ready); end
    v1 = 1; v2 = 1; i1 = ind(32'h3f0); i2 = ind(32'h3f4);
    tick(); v1 = 0; v2 = 0;
    n_cmp++; if (cnt !== 4'd8) begin n_err++; $display("FAIL full_reject: got %0d required 8", cnt); end
    r1 = 1; r2 = 1; tick();
    n_cmp++; if (cnt !== 4'd6 || in_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen: got cnt %0d rdy %b required 6 1", cnt, in_ready); end
    push_pair(ind(32'h340), ind(32'h344));
    n_cmp++; if (cnt !== 4'd6) begin n_err++; $display("FAIL two_in_two_out: got %0d required 6", cnt); end
    for (int k = 2; k >= 0; k--) begin
      tick();
      n_cmp++; if (cnt !== 4'(2 * k)) begin n_err++; $display("FAIL full_drain_%0d: got %0d required %0d", k, cnt, 2 * k); end
    end
    r1 = 0; r2 = 0;
    for (int k = 0; k < 3; k++) push_pair(ind(32'h350 + 8 * k), ind(32'h354 + 8 * k));
    push_one(ind(32'h370));
    n_cmp++; if (cnt !== 4'd7 || in_ready !== 1'b0) begin n_err++; $display("FAIL one_free: got cnt %0d rdy %b required 7 0", cnt, in_ready); end
    r1 = 1; v1 = 1; v2 = 1; i1 = ind(32'h3e0); i2 = ind(32'h3e4);
    tick(); v1 = 0; v2 = 0;
    n_cmp++; if (cnt !== 4'd6) begin n_err++; $display("FAIL one_free_no_credit: got %0d required 6", cnt); end
    r2 = 1; tick(); tick(); tick(); r1 = 0; r2 = 0;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL one_free_drain: got %0d required 0", cnt); end
  endtask

  task automatic test_flush();
    push_pair(ind(32'h500), ind(32'h504));
    push_pair(ind(32'h508), ind(32'h50c));
    push_one(ind(32'h510));
    n_cmp++; if (cnt !== 4'd5) begin n_err++; $display("FAIL flush_pre: got %0d required 5", cnt); end
    flush = 1; v1 = 1; v2 = 1; i1 = ind(32'h520); i2 = ind(32'h524); r1 = 1; r2 = 1;
    #1;
    n_cmp++; if (ov1 !== 1'b0 || ov2 !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL flush_gate: got v %b%b rdy %b required 00 0", ov1, ov2, in_ready); end
    tick();
    flush = 0; v1 = 0; v2 = 0; r1 = 0; r2 = 0;
    sb.delete();
    n_cmp++; if (cnt !== 4'd0 || ov1 !== 1'b0) begin n_err++; $display("FAIL flush_clear: got cnt %0d v %b required 0 0", cnt, ov1); end
    push_one(ind(32'h5a0));
    n_cmp++; if (cnt !== 4'd1 || oi1[31:0] !== 32'h5a0) begin n_err++; $display("FAIL flush_after: got cnt %0d pc %h required 1 5a0", cnt, oi1[31:0]); end
    r1 = 1; tick(); r1 = 0;
  endtask

  task automatic test_reset_mid();
    push_pair(ind(32'h700), ind(32'h704));
    push_one(ind(32'h708));
    rst = 1; tick(); rst = 0;
    sb.delete();
    n_cmp++; if (cnt !== 4'd0 || ov1 !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid: got cnt %0d v %b rdy %b required 0 0 1", cnt, ov1, in_ready); end
    n_cmp++; if (oi1 !== 64'd0 || oi2 !== 64'd0) begin n_err++; $display("FAIL rst_mid_inst: got %h %h required 0 0", oi1, oi2); end
  endtask

  task automatic test_ready2_only();
    push_pair(ind(32'h800), ind(32'h804));
    r2 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (cnt !== 4'd2 || ov2 !== 1'b1) begin n_err++; $display("FAIL ready2_only_%0d: got cnt %0d v2 %b required 2 1", k, cnt, ov2); end
    end
    r1 = 1; tick(); r1 = 0; r2 = 0;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL ready2_drain: got %0d required 0", cnt); end
  endtask

  task automatic test_back_to_back();
    r1 = 1; r2 = 1;
    for (int k = 0; k < 10; k++) begin
      push_pair(ind(32'h900 + 8 * k), ind(32'h904 + 8 * k));
      n_cmp++; if (cnt !== 4'd2 || ov2 !== 1'b1) begin n_err++; $display("FAIL b2b_%0d: got cnt %0d v2 %b required 2 1", k, cnt, ov2); end
    end
    tick(); r1 = 0; r2 = 0;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL b2b_drain: got %0d required 0", cnt); end
  endtask

  task automatic test_single_issue_wrap();
    int sent = 0;
    int mc = 0;
    int cyc = 0;
    int wr;
    logic exp_rdy;
    s_r1 = 1; s_r2 = 1;
    while ((sent < 20 || mc > 0) && cyc < 200) begin
      exp_rdy = (DEPTH - mc) >= 2;
      n_cmp++; if (s_in_ready !== exp_rdy || s_cnt !== 4'(mc) || s_ov2 !== 1'b0) begin
        n_err++; $display("FAIL single_issue_c%0d: got rdy %b cnt %0d v2 %b required %b %0d 0", cyc, s_in_ready, s_cnt, s_ov2, exp_rdy, mc);
      end
      wr = 0; s_v1 = 0; s_v2 = 0;
      if (exp_rdy && sent < 20) begin
        s_v1 = 1; s_i1 = ind(32'h1000 + 4 * sent); sb_s.push_back(s_i1); sent++; wr++;
        if (sent < 20) begin
          s_v2 = 1; s_i2 = ind(32'h1000 + 4 * sent); sb_s.push_back(s_i2); sent++; wr++;
        end
      end
      tick();
      mc = mc + wr - ((mc >= 1) ? 1 : 0);
      cyc++;
    end
    s_v1 = 0; s_v2 = 0; s_r1 = 0; s_r2 = 0;
    n_cmp++; if (cyc >= 200) begin n_err++; $display("FAIL single_issue_timeout: got %0d cycles required < 200", cyc); end
    n_cmp++; if (s_cnt !== 4'd0 || sb_s.size() != 0) begin n_err++; $display("FAIL single_issue_end: got cnt %0d pending %0d required 0 0", s_cnt, sb_s.size()); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_raw_split();
    test_hazards();
    test_nop_compaction();
    test_fill_full();
    test_flush();
    test_reset_mid();
    test_ready2_only();
    test_back_to_back();
    test_single_issue_wrap();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
